// File: rtl/fifo_uart_pkg.sv
// Shared types and line-level constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        IDLE_LEVEL  = 1'b1;
  localparam logic        START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: held at zero while cleared, otherwise wraps at the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from an upstream registered-output FIFO.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_en_o,
  input  logic [DATA_BITS-1:0] fifo_data_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 rd_en_q, rd_en_d;
  logic                 armed_q;
  logic                 can_start_s;
  logic                 baud_clr_s;
  logic                 tick_s;

  // The counter is held cleared until the frame proper starts, so START always begins at zero.
  assign baud_clr_s = (state_q == ST_IDLE) || (state_q == ST_POP) || (state_q == ST_LOAD);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (baud_clr_s),
    .tick (tick_s)
  );

  // armed_q delays the first pop after reset release by one extra edge.
  assign can_start_s = enable_i && !fifo_empty_i && armed_q;

  // Next-state, shift register and registered-output lookahead.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (can_start_s) state_d = ST_POP;
        else             state_d = ST_IDLE;
      end
      ST_POP: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d = fifo_data_i;
        idx_d   = 3'd0;
        state_d = ST_START;
      end
      ST_START: begin
        if (tick_s) state_d = ST_DATA;
        else        state_d = ST_START;
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          if (can_start_s) state_d = ST_POP;
          else             state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_en_d = (state_d == ST_POP);
    case (state_d)
      ST_START: tx_d = START_LEVEL;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = IDLE_LEVEL;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= 3'd0;
      tx_q    <= IDLE_LEVEL;
      rd_en_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      armed_q <= 1'b1;
    end
  end

  assign tx_o         = tx_q;
  assign fifo_rd_en_o = rd_en_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = (state_q == ST_STOP) && tick_s;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit; legal values are 2 or more.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable_i  input  1  when high, the block may start new frames.
REQ-005 fifo_empty_i  input  1  empty flag of the upstream 8-deep byte FIFO.
REQ-006 fifo_rd_en_o  output  1  one-cycle pop request to the FIFO.
REQ-007 fifo_data_i  input  8  FIFO read data, registered by the FIFO and valid the cycle after the pop.
REQ-008 tx_o  output  1  serial line in 8N1 format, idle high.
REQ-009 busy_o  output  1  high in every state except IDLE.
REQ-010 frame_done_o  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-011 The FSM SHALL have six states: IDLE, POP, LOAD, START, DATA, STOP.
REQ-012 IDLE transition: go to POP when enable_i=1 and fifo_empty_i=0; otherwise stay in IDLE.
REQ-013 POP: fifo_rd_en_o=1 for exactly one cycle, then go to LOAD; fifo_rd_en_o SHALL be registered and 0 in every other state.
REQ-014 LOAD: capture fifo_data_i into an 8-bit shift register at the end of the cycle, then go to START.
REQ-015 START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-016 DATA: send 8 bits LSB first, each held for CLKS_PER_BIT cycles, then go to STOP.
REQ-017 Bit position: a 3-bit index counts 0..7; index 7 at the bit's final cycle triggers the move to STOP.
REQ-018 STOP: tx_o=1 for CLKS_PER_BIT cycles, with frame_done_o=1 on the final cycle.
REQ-019 After STOP: go to POP if enable_i=1 and fifo_empty_i=0 on the final stop cycle; otherwise go to IDLE.
REQ-020 Back-to-back frames SHALL be separated by exactly 2 idle-high cycles (POP and LOAD).
REQ-021 Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, wraps to 0, and clears on each entry to START.
REQ-022 tx_o SHALL be registered and driven high in IDLE, POP and LOAD.
REQ-023 A pop SHALL never be issued while fifo_empty_i=1, and at most one pop SHALL be issued per frame.
REQ-024 If enable_i deasserts mid-frame, the current frame SHALL complete unchanged, with no further pops.
REQ-025 fifo_data_i SHALL be ignored outside LOAD.
REQ-026 A change on fifo_empty_i during START, DATA or STOP SHALL have no effect on the frame in progress.

Reset
REQ-027 While rst_n=0, the block SHALL immediately force: state=IDLE, tx_o=1, fifo_rd_en_o=0, busy_o=0, frame_done_o=0, counters=0, shift register=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame, return tx_o high immediately, and not resume the frame after reset.
REQ-029 After rst_n rises, the first pop SHALL occur no earlier than the second rising edge.

Structure
REQ-030 Package fifo_uart_pkg SHALL hold the state enum typedef and the constants DATA_BITS=8, IDLE_LEVEL=1'b1 and START_LEVEL=1'b0.
REQ-031 The baud counter SHALL be one sub-module, uart_baud_cnt, with inputs clk, rst_n, clr and outputs tick (last cycle of a bit).
REQ-032 The FSM and the shift register SHALL reside in fifo_uart_tx.

Verification (CLKS_PER_BIT=4)
REQ-033 Single byte: FIFO holds 0xA5, enable_i=1 -> one pop; tx_o = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; one frame_done_o pulse; busy_o low afterwards.
REQ-034 Back-to-back: FIFO holds 0x00 and 0xFF -> two pops; exactly 2 high cycles between the first stop bit and the second start bit; two frame_done_o pulses.
REQ-035 Empty FIFO: fifo_empty_i=1, enable_i=1 for 100 cycles -> fifo_rd_en_o never asserts; tx_o stays high; busy_o=0.
REQ-036 Enable drop: enable_i falls during bit 3 of 0x3C with 0x55 still queued -> 0x3C completes, no second pop, block returns to IDLE.
REQ-037 Reset mid-frame: rst_n low during bit 5 -> tx_o=1 and busy_o=0 in the same cycle; after release, the next frame starts with a fresh pop.
REQ-038 Pop timing: fifo_rd_en_o is high for exactly 1 cycle; the data captured is the FIFO data_o of the cycle after the pop.
